pulse_pick_sequencer: RTL and testbench

- Sequences the pulse picker through a programmable shot table.
- Each table entry holds delay, width and shot count. Shots are issued one at a time by triggering the picker and waiting for it to return to ready.
- If a laser pulse is lost and the picker hangs, a timeout issues the picker's init and the sequence continues.
- Runs in the picker's clock domain, between the host register interface and the picker's trigger/config/ready pins.

---
 rtl/pulse_seq_pkg.sv | 29 ++
 rtl/pulse_seq_table.sv | 30 +++
 rtl/pulse_pick_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pulse_pick_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse-picker shot sequencer.
package pulse_seq_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefToW   = 16;
  localparam int unsigned EntryW   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StTrig,
    StFire,
    StNext,
    StDone,
    StRecover
  } state_e;

  typedef struct packed {
    logic [EntryW-1:0] count;
    logic [EntryW-1:0] width;
    logic [EntryW-1:0] delay;
  } entry_t;

  function automatic logic [EntryW-1:0] sat_inc(input logic [EntryW-1:0] v);
    return (v == '1) ? v : v + EntryW'(1);
  endfunction

endpackage

// File: rtl/pulse_seq_table.sv
// Shot table: DEPTH x {count, width, delay} register file, synchronous write,
// asynchronous read, cleared by reset.
module pulse_seq_table
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  wClk_i,
  input  logic                  wReset_i,
  input  logic                  wWrEn_i,
  input  logic [ADDR_W-1:0]     wWrAddr_i,
  input  logic [3*EntryW-1:0]   wWrData_i,
  input  logic [ADDR_W-1:0]     wRdAddr_i,
  output logic [3*EntryW-1:0]   wRdData_o
);

  logic [3*EntryW-1:0] mem_q [DEPTH];

  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      mem_q <= '{default: '0};
    end else if (wWrEn_i) begin
      mem_q[wWrAddr_i] <= wWrData_i;
    end
  end

  assign wRdData_o = mem_q[wRdAddr_i];

endmodule

// File: rtl/pulse_pick_sequencer.sv
// Walks the shot table, triggering the picker once per shot and waiting for it to
// return to ready; hung shots time out into a 2-cycle picker init.
module pulse_pick_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned TO_W   = DefToW
) (
  input  logic              wClk_i,
  input  logic              wReset_i,
  input  logic              wWrEn_i,
  input  logic [ADDR_W-1:0] wWrAddr_i,
  input  logic [7:0]        wWrDelay_i,
  input  logic [7:0]        wWrWidth_i,
  input  logic [7:0]        wWrCount_i,
  input  logic [ADDR_W:0]   wNumEntries_i,
  input  logic              wLoop_i,
  input  logic              wStart_i,
  input  logic              wAbort_i,
  input  logic [TO_W-1:0]   wTimeout_i,
  input  logic              wReady_i,
  output logic              wTrig_o,
  output logic [7:0]        wDelay_o,
  output logic [7:0]        wWidth_o,
  output logic              wInit_o,
  output logic              wBusy_o,
  output logic              wDone_o,
  output logic [7:0]        wLostCount_o
);

  state_e            state_q;
  logic              start_q;
  logic [ADDR_W:0]   idx_q;
  logic [7:0]        delay_q, width_q, remain_q, lost_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              rec_cnt_q, rec_abort_q;
  logic              trig_q, init_q, busy_q, done_q;

  logic [3*EntryW-1:0] rd_data;
  entry_t              rd_entry;
  logic                start_rise, abort_hit, to_hit;
  logic [TO_W-1:0]     to_inc;
  logic [ADDR_W:0]     idx_inc;
  logic [7:0]          remain_dec;

  pulse_seq_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .wClk_i    (wClk_i),
    .wReset_i  (wReset_i),
    .wWrEn_i   (wWrEn_i),
    .wWrAddr_i (wWrAddr_i),
    .wWrData_i ({wWrCount_i, wWrWidth_i, wWrDelay_i}),
    .wRdAddr_i (idx_q[ADDR_W-1:0]),
    .wRdData_o (rd_data)
  );

  assign rd_entry   = entry_t'(rd_data);
  assign start_rise = wStart_i & ~start_q;
  assign abort_hit  = wAbort_i && (state_q != StIdle) && (state_q != StRecover);
  // Counter saturates rather than wrapping, so a huge timeout can never alias.
  assign to_inc     = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
  assign to_hit     = (wTimeout_i != '0) && (to_inc == wTimeout_i);
  assign idx_inc    = idx_q + (ADDR_W + 1)'(1);
  assign remain_dec = remain_q - 8'd1;

  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      idx_q       <= '0;
      delay_q     <= '0;
      width_q     <= '0;
      remain_q    <= '0;
      lost_q      <= '0;
      to_cnt_q    <= '0;
      rec_cnt_q   <= 1'b0;
      rec_abort_q <= 1'b0;
      trig_q      <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_q <= wStart_i;
      trig_q  <= 1'b0;
      init_q  <= 1'b0;
      done_q  <= 1'b0;
      if (abort_hit) begin
        state_q     <= StRecover;
        rec_cnt_q   <= 1'b0;
        rec_abort_q <= 1'b1;
        init_q      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_rise && (wNumEntries_i != '0)) begin
              state_q <= StLoad;
              idx_q   <= '0;
              lost_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          StLoad: begin
            remain_q <= rd_entry.count;
            if (rd_entry.count == '0) begin
              state_q <= StNext;
            end else begin
              delay_q <= rd_entry.delay;
              width_q <= rd_entry.width;
              state_q <= StArm;
            end
          end
          StArm: begin
            to_cnt_q <= '0;
            if (wReady_i) begin
              state_q <= StTrig;
              trig_q  <= 1'b1;
            end
          end
          StTrig: begin
            to_cnt_q <= to_inc;
            if (to_hit) begin
              state_q     <= StRecover;
              rec_cnt_q   <= 1'b0;
              rec_abort_q <= 1'b0;
              init_q      <= 1'b1;
              lost_q      <= sat_inc(lost_q);
            end else if (!wReady_i) begin
              state_q <= StFire;
            end else begin
              trig_q <= 1'b1;
            end
          end
          StFire: begin
            to_cnt_q <= to_inc;
            if (to_hit) begin
              state_q     <= StRecover;
              rec_cnt_q   <= 1'b0;
              rec_abort_q <= 1'b0;
              init_q      <= 1'b1;
              lost_q      <= sat_inc(lost_q);
            end else if (wReady_i) begin
              remain_q <= remain_dec;
              state_q  <= (remain_dec != '0) ? StArm : StNext;
            end
          end
          StNext: begin
            if (idx_inc >= wNumEntries_i) begin
              if (wLoop_i) begin
                idx_q   <= '0;
                state_q <= StLoad;
              end else begin
                idx_q   <= idx_inc;
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q   <= idx_inc;
              state_q <= StLoad;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          StRecover: begin
            if (wAbort_i) rec_abort_q <= 1'b1;
            if (!rec_cnt_q) begin
              rec_cnt_q <= 1'b1;
              init_q    <= 1'b1;
            end else if (rec_abort_q || wAbort_i) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              // A timed-out shot still counts as issued.
              remain_q <= remain_dec;
              state_q  <= (remain_dec != '0) ? StArm : StNext;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wTrig_o      = trig_q;
  assign wDelay_o     = delay_q;
  assign wWidth_o     = width_q;
  assign wInit_o      = init_q;
  assign wBusy_o      = busy_q;
  assign wDone_o      = done_q;
  assign wLostCount_o = lost_q;

endmodule

// File: tb/tb_pulse_pick_sequencer.sv
// Randomised and directed bench for pulse_pick_sequencer with a reactive picker
// model and a shot-list scoreboard built from the table contents.
module tb_pulse_pick_sequencer;

  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  localparam int TO_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wWrEn_i = 1'b0;
  logic [ADDR_W-1:0] wWrAddr_i = '0;
  logic [7:0]        wWrDelay_i = '0, wWrWidth_i = '0, wWrCount_i = '0;
  logic [ADDR_W:0]   wNumEntries_i = '0;
  logic              wLoop_i = 1'b0, wStart_i = 1'b0, wAbort_i = 1'b0;
  logic [TO_W-1:0]   wTimeout_i = '0;
  logic              wReady_i;
  logic              wTrig_o, wInit_o, wBusy_o, wDone_o;
  logic [7:0]        wDelay_o, wWidth_o, wLostCount_o;

  pulse_pick_sequencer #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .wClk_i(clk), .wReset_i(rst), .wWrEn_i(wWrEn_i), .wWrAddr_i(wWrAddr_i),
    .wWrDelay_i(wWrDelay_i), .wWrWidth_i(wWrWidth_i), .wWrCount_i(wWrCount_i),
    .wNumEntries_i(wNumEntries_i), .wLoop_i(wLoop_i), .wStart_i(wStart_i),
    .wAbort_i(wAbort_i), .wTimeout_i(wTimeout_i), .wReady_i(wReady_i),
    .wTrig_o(wTrig_o), .wDelay_o(wDelay_o), .wWidth_o(wWidth_o), .wInit_o(wInit_o),
    .wBusy_o(wBusy_o), .wDone_o(wDone_o), .wLostCount_o(wLostCount_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int d; int w; } shot_t;
  shot_t exp_q[$];
  int m_delay[DEPTH], m_width[DEPTH], m_count[DEPTH];
  int n_cmp = 0, n_fail = 0;
  int trig_seen = 0, done_seen = 0, init_seen = 0, t_trig = 0, t_init = 0;
  int hang_left = 0, hang_total = 0;
  bit pk_hung = 1'b0;
  bit trig_p = 1'b0, init_p = 1'b0, done_p = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Picker model: drops ready 2-3 cycles after a trigger edge, stays busy a few
  // cycles, or hangs low until it sees init.
  initial begin
    int pk_st, pk_cnt;
    bit tp;
    wReady_i = 1'b1;
    pk_st = 0; pk_cnt = 0; tp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wReady_i = 1'b1; pk_st = 0; pk_hung = 1'b0;
      end else if (wInit_o) begin
        wReady_i = 1'b1; pk_st = 0;
      end else begin
        case (pk_st)
          0: if (wTrig_o && !tp) begin
            pk_cnt = $urandom_range(1, 2);
            pk_st = 1;
            pk_hung = (hang_left > 0);
            if (pk_hung) begin hang_left--; hang_total++; end
          end
          1: begin
            pk_cnt--;
            if (pk_cnt == 0) begin wReady_i = 1'b0; pk_st = 2; pk_cnt = $urandom_range(2, 6); end
          end
          default: if (!pk_hung) begin
            pk_cnt--;
            if (pk_cnt == 0) begin wReady_i = 1'b1; pk_st = 0; end
          end
        endcase
      end
      tp = wTrig_o;
    end
  end

  // Compare process: every trigger edge must match the next scheduled shot.
  initial begin
    shot_t s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("trig_init_exclusive", int'(wTrig_o & wInit_o), 0);
        if (wTrig_o | wInit_o | wDone_o) check("busy_when_active", int'(wBusy_o), 1);
        if (wTrig_o && !trig_p) begin
          trig_seen++;
          t_trig = cyc;
          if (exp_q.size() == 0) check("unexpected_trig", 1, 0);
          else begin
            s = exp_q.pop_front();
            check("trig_delay", int'(wDelay_o), s.d);
            check("trig_width", int'(wWidth_o), s.w);
          end
        end
        if (wInit_o && !init_p) begin
          init_seen++;
          t_init = cyc;
          if (pk_hung) check("timeout_latency", cyc - t_trig, int'(wTimeout_i));
        end
        if (!wInit_o && init_p) check("init_len", cyc - t_init, 2);
        if (wDone_o) begin
          check("done_one_cycle", int'(done_p), 0);
          if (!done_p) begin
            done_seen++;
            check("done_queue_empty", exp_q.size(), 0);
          end
        end
      end
      trig_p = wTrig_o; init_p = wInit_o; done_p = wDone_o;
    end
  end

  task automatic write_entry(input int a, input int d, input int w, input int c);
    @(negedge clk);
    wWrEn_i = 1'b1; wWrAddr_i = ADDR_W'(a);
    wWrDelay_i = 8'(d); wWrWidth_i = 8'(w); wWrCount_i = 8'(c);
    @(negedge clk);
    wWrEn_i = 1'b0;
    m_delay[a] = d; m_width[a] = w; m_count[a] = c;
  endtask

  task automatic push_shot(input int a);
    shot_t s;
    s.d = m_delay[a]; s.w = m_width[a];
    exp_q.push_back(s);
  endtask

  task automatic build_expect(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < m_count[i]; k++) push_shot(i);
  endtask

  task automatic pulse_start();
    @(negedge clk); wStart_i = 1'b1;
    @(negedge clk); wStart_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_seen > d0) break;
    end
    if (done_seen <= d0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_trigs(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (trig_seen >= target) break;
    end
    if (trig_seen < target) check("trig_timeout", trig_seen, target);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!wBusy_o) break;
    end
    check("idle_reached", int'(wBusy_o), 0);
  endtask

  task automatic run_seq(input int n, output int trigs);
    int t0, d0;
    exp_q.delete();
    build_expect(n);
    t0 = trig_seen; d0 = done_seen; hang_total = 0;
    wNumEntries_i = (ADDR_W + 1)'(n);
    pulse_start();
    wait_done(d0, 2000);
    repeat (2) @(negedge clk);
    check("busy_after_done", int'(wBusy_o), 0);
    trigs = trig_seen - t0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"}, int'(wTrig_o), 0);
    check({tag, "_delay"}, int'(wDelay_o), 0);
    check({tag, "_width"}, int'(wWidth_o), 0);
    check({tag, "_init"}, int'(wInit_o), 0);
    check({tag, "_busy"}, int'(wBusy_o), 0);
    check({tag, "_done"}, int'(wDone_o), 0);
    check({tag, "_lost"}, int'(wLostCount_o), 0);
  endtask

  initial begin
    int tr, t0, d0, i0, n, tot;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single entry, start-to-trigger latency pinned by hand.
    write_entry(0, 5, 3, 2);
    wNumEntries_i = 3'd1;
    exp_q.delete(); build_expect(1);
    t0 = trig_seen; d0 = done_seen;
    @(negedge clk); wStart_i = 1'b1;
    @(posedge clk); #1 check("lat_load", int'(wTrig_o), 0);
    @(posedge clk); #1 check("lat_arm", int'(wTrig_o), 0);
    @(posedge clk); #1 check("lat_trig", int'(wTrig_o), 1);
    check("lat_delay", int'(wDelay_o), 5);
    check("lat_width", int'(wWidth_o), 3);
    wStart_i = 1'b0;
    wait_done(d0, 500);
    check("single_trigs", trig_seen - t0, 2);
    check("single_lost", int'(wLostCount_o), 0);

    // Skipped zero-count entry.
    write_entry(0, 11, 1, 1);
    write_entry(1, 22, 2, 0);
    write_entry(2, 33, 3, 2);
    run_seq(3, tr);
    check("skip_trigs", tr, 3);

    // Hung first shot times out, sequence still completes.
    wTimeout_i = 16'd20;
    write_entry(0, 4, 4, 1);
    write_entry(1, 6, 6, 1);
    i0 = init_seen;
    hang_left = 1;
    run_seq(2, tr);
    check("timeout_trigs", tr, 2);
    check("timeout_lost", int'(wLostCount_o), 1);
    check("timeout_inits", init_seen - i0, 1);
    hang_left = 0;

    // Looping, then abort during FIRE.
    write_entry(0, 10, 1, 1);
    write_entry(1, 20, 2, 1);
    exp_q.delete();
    for (int k = 0; k < 6; k++) push_shot(k % 2);
    wLoop_i = 1'b1; wNumEntries_i = 3'd2;
    t0 = trig_seen; d0 = done_seen; i0 = init_seen;
    pulse_start();
    wait_trigs(t0 + 5, 600);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!wTrig_o && !wReady_i && wBusy_o) break;
    end
    wAbort_i = 1'b1;
    @(negedge clk); wAbort_i = 1'b0;
    wait_idle(20);
    check("abort_trigs", trig_seen - t0, 5);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_inits", init_seen - i0, 1);
    exp_q.delete();

    // Rewrite entry 0 while its shot is in flight.
    write_entry(0, 5, 3, 1);
    write_entry(1, 7, 4, 1);
    exp_q.delete();
    push_shot(0); push_shot(1);
    t0 = trig_seen;
    pulse_start();
    wait_trigs(t0 + 1, 200);
    write_entry(0, 9, 3, 1);
    push_shot(0);
    check("inflight_delay", int'(wDelay_o), 5);
    wait_trigs(t0 + 3, 400);
    check("reload_delay", int'(wDelay_o), 9);
    wAbort_i = 1'b1;
    @(negedge clk); wAbort_i = 1'b0;
    wait_idle(20);
    exp_q.delete();
    wLoop_i = 1'b0;

    // Asynchronous reset while triggering.
    write_entry(0, 50, 60, 1);
    wNumEntries_i = 3'd1;
    exp_q.delete(); build_expect(1);
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wTrig_o) break;
    end
    check("pre_reset_trig", int'(wTrig_o), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin m_delay[i] = 0; m_width[i] = 0; m_count[i] = 0; end
    run_seq(DEPTH, tr);
    check("cleared_table_trigs", tr, 0);

    // Start ignored with no entries.
    wNumEntries_i = '0;
    pulse_start();
    repeat (4) @(negedge clk);
    check("zero_entries_busy", int'(wBusy_o), 0);

    // Randomised sequences.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH);
      tot = 0;
      for (int i = 0; i < n; i++) begin
        write_entry(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
        tot += m_count[i];
      end
      if (r % 3 == 0) begin
        wTimeout_i = 16'($urandom_range(20, 30));
        hang_left = $urandom_range(0, 2);
      end else begin
        wTimeout_i = '0;
        hang_left = 0;
      end
      run_seq(n, tr);
      check("rand_trigs", tr, tot);
      check("rand_lost", int'(wLostCount_o), hang_total);
      hang_left = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
